// File: rtl/dc_mcarb.sv
// Display-refresh arbiter: shares one MC port between CRT0 and CRT1, tracks accepted
// bursts in an in-order tag queue and steers returning beats to the owning CRT FIFO.
module dc_mcarb #(
  parameter int OUTS_DEPTH = 4
) (
  input  logic        mclock,
  input  logic        hreset,
  input  logic        req0,
  input  logic        req1,
  input  logic        urg0,
  input  logic        urg1,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [11:0] y0,
  input  logic [11:0] y1,
  input  logic [4:0]  pg0,
  input  logic [4:0]  pg1,
  input  logic [20:0] base0,
  input  logic [20:0] base1,
  output logic        mc_req,
  output logic        mc_sel,
  output logic [9:0]  mc_x,
  output logic [11:0] mc_y,
  output logic [4:0]  mc_pg,
  output logic [20:0] mc_base,
  input  logic        mc_ready,
  input  logic        mcpush,
  output logic        ready0,
  output logic        ready1,
  output logic        push0,
  output logic        push1,
  output logic        outs_full,
  output logic        err_orph
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUTS_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          sel_q, sel_d;
  logic [9:0]    x_q, x_d;
  logic [11:0]   y_q, y_d;
  logic [4:0]    pg_q, pg_d;
  logic [20:0]   base_q, base_d;
  logic          rr_q, rr_d;
  logic          mask0_q, mask0_d;
  logic          mask1_q, mask1_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bcnt_q, bcnt_d;
  logic          full_q, full_d;
  logic          orph_q, orph_d;
  logic          tag_sel_q   [OUTS_DEPTH];
  logic [5:0]    tag_beats_q [OUTS_DEPTH];

  logic          elig0_s, elig1_s, win_s, enq_s, pop_s, fwd_s, nonempty_s;
  logic          head_sel_s;
  logic [5:0]    head_beats_s, beats_s;

  // Arbitration and request-presentation FSM
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    pg_d    = pg_q;
    base_d  = base_q;
    rr_d    = rr_q;
    mask0_d = 1'b0;
    mask1_d = 1'b0;
    enq_s   = 1'b0;
    ready0  = 1'b0;
    ready1  = 1'b0;
    elig0_s = req0 & ~mask0_q;
    elig1_s = req1 & ~mask1_q;
    if (elig0_s && elig1_s) begin
      if ((urg0 & elig0_s) != (urg1 & elig1_s)) begin
        win_s = urg1;
      end else begin
        win_s = ~rr_q;
      end
    end else begin
      win_s = elig1_s;
    end
    case (state_q)
      ST_IDLE: begin
        if (!full_q && (elig0_s || elig1_s)) begin
          state_d = ST_ISSUE;
          sel_d   = win_s;
          x_d     = win_s ? x1 : x0;
          y_d     = win_s ? y1 : y0;
          pg_d    = win_s ? pg1 : pg0;
          base_d  = win_s ? base1 : base0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mc_ready) begin
          ready0  = ~sel_q;
          ready1  = sel_q;
          enq_s   = 1'b1;
          rr_d    = sel_q;
          mask0_d = ~sel_q;
          mask1_d = sel_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d = (state_d == ST_ISSUE);
  end

  // Tag queue bookkeeping and return-beat steering
  always_comb begin
    beats_s      = (pg_q == 5'd0) ? 6'd32 : {1'b0, pg_q};
    nonempty_s   = (cnt_q != {CW{1'b0}});
    head_sel_s   = tag_sel_q[rd_ptr_q];
    head_beats_s = tag_beats_q[rd_ptr_q];
    fwd_s        = mcpush & nonempty_s;
    push0        = fwd_s & ~head_sel_s;
    push1        = fwd_s & head_sel_s;
    pop_s        = fwd_s && (bcnt_q == (head_beats_s - 6'd1));
    if (pop_s) begin
      bcnt_d = 6'd0;
    end else if (fwd_s) begin
      bcnt_d = bcnt_q + 6'd1;
    end else begin
      bcnt_d = bcnt_q;
    end
    wr_ptr_d = enq_s ? (wr_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : rd_ptr_q;
    case ({enq_s, pop_s})
      2'b10:   cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == DEPTH_C);
    orph_d = orph_q | (mcpush & ~nonempty_s);
  end

  // State and output registers
  always_ff @(posedge mclock or negedge hreset) begin
    if (!hreset) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      sel_q    <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 12'd0;
      pg_q     <= 5'd0;
      base_q   <= 21'd0;
      rr_q     <= 1'b1;
      mask0_q  <= 1'b0;
      mask1_q  <= 1'b0;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      bcnt_q   <= 6'd0;
      full_q   <= 1'b0;
      orph_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pg_q     <= pg_d;
      base_q   <= base_d;
      rr_q     <= rr_d;
      mask0_q  <= mask0_d;
      mask1_q  <= mask1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      full_q   <= full_d;
      orph_q   <= orph_d;
    end
  end

  // Tag storage: owner and beat count of each accepted burst
  always_ff @(posedge mclock or negedge hreset) begin
    if (!hreset) begin
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        tag_sel_q[i]   <= 1'b0;
        tag_beats_q[i] <= 6'd0;
      end
    end else if (enq_s) begin
      tag_sel_q[wr_ptr_q]   <= sel_q;
      tag_beats_q[wr_ptr_q] <= beats_s;
    end
  end

  assign mc_req    = req_q;
  assign mc_sel    = sel_q;
  assign mc_x      = x_q;
  assign mc_y      = y_q;
  assign mc_pg     = pg_q;
  assign mc_base   = base_q;
  assign outs_full = full_q;
  assign err_orph  = orph_q;

endmodule
